vdg_text_pipeline: RTL and testbench
====================================

Name: vdg_text_pipeline

Overview:
- Parametrised text/semigraphics pixel generator for the MC6847-family video path.
- Walks video RAM one character row at a time and fetches glyph lines from an external character ROM.
- Applies glyph-line padding, per-character inverse and SG4 semigraphics, then serialises 8 pixels per character.
- Sits between VRAM/char-ROM and the colour/sync stage; generalises the fixed 12-line cell with a 3-line top pad to configurable geometry.

Parameters:
COLS, 32, characters per text row
ROWS, 16, text rows per frame
CELL_H, 12, scanlines per character cell (2..16)
GLYPH_H, 8, glyph lines stored in ROM per character (power of 2, <= CELL_H)
TOP_PAD, 3, blank lines above the glyph inside a cell (TOP_PAD+GLYPH_H <= CELL_H)
ADDR_W, 13, VRAM address width
ROM_AW, 9, char ROM address width (= 6 + log2(GLYPH_H))

Ports:
clk  in  1  pixel-domain clock
reset  in  1  asynchronous, active-high reset
clk_ena  in  1  pixel enable; all state advances only when high
frame_start  in  1  pulse (sampled with clk_ena): start of frame
line_start  in  1  pulse (sampled with clk_ena): start of scanline, 8 enabled cycles before first visible pixel
vram_base  in  ADDR_W  frame base address in VRAM
vram_addr  out  ADDR_W  VRAM read address
vram_data  in  8  VRAM byte, valid 1 enabled cycle after vram_addr
rom_addr  out  ROM_AW  char ROM address {code[5:0], glyph_line}
rom_data  in  8  ROM byte, valid 1 enabled cycle after rom_addr
pix_on  out  1  current pixel foreground
pix_sg  out  1  current pixel from semigraphics character
pix_color  out  3  SG colour (vram bits 6:4); 0 for text
pix_valid  out  1  high during visible pixels

Behaviour:
- Reset: all counters, state and outputs 0; state IDLE. Reset mid-line aborts immediately; no resumption.
- States:
  - IDLE: line_start -> PREFETCH, slot counter k = 0, column = 0.
  - PREFETCH: 8 enabled cycles fetching column 0 -> ACTIVE.
  - ACTIVE: COLS*8 enabled cycles; after the last pixel -> IDLE.
  - line_start in PREFETCH/ACTIVE restarts PREFETCH (column 0; row counters still advance).
- Slot schedule, k = 0..7 per character, enabled cycles:
  - k=0: drive vram_addr = vram_base + text_row*COLS + fetch_col.
  - k=2: latch vram_data.
  - k=3: drive rom_addr.
  - k=5: latch rom_data.
  - k=7: load the 8-bit shifter, pixels shown MSB first from the next k=0.
  - First visible pixel appears exactly 8 enabled cycles after line_start.
- Row counting:
  - frame_start clears line_in_cell and text_row.
  - Each line_start after the first in a frame increments line_in_cell; wrapping at CELL_H-1 increments text_row.
  - text_row >= ROWS: pix_valid still asserted, pix_on = 0, no VRAM reads issued (vram_addr holds).
- Glyph line: g = line_in_cell - TOP_PAD. If line_in_cell < TOP_PAD or g >= GLYPH_H, the glyph byte is forced to 0x00 (ROM still addressed with g[ log2(GLYPH_H)-1:0 ]).
- Text character, vram bit7 = 0:
  - bit6 = 1 -> glyph XOR 0xFF, so pad lines are fully lit.
  - pix_sg = 0, pix_color = 0.
- SG4 character, vram bit7 = 1:
  - Upper half (line_in_cell < CELL_H/2) uses bits 3 (left 4 px) and 2 (right 4 px); lower half uses bits 1 and 0.
  - pix_sg = 1, pix_color = bits 6:4; no inversion; padding does not apply.
- Address arithmetic: modulo 2^ADDR_W (wraps silently).
- clk_ena low: everything holds, outputs included.
- pix_valid = 1 only in ACTIVE.

Test Plan:
- Defaults; frame_start, then line_start at line_in_cell=3; VRAM[base]=0x01, ROM[8]=0xA5 -> rom_addr=0x008; pixels 1,0,1,0,0,1,0,1 starting 8 enabled cycles after line_start; pix_valid high for 256 cycles.
- Same char with bit6 set (0x41) on line 0 -> 8 pixels all 1; on line 3 -> ~0xA5 = 0x5A.
- SG byte 0x9A (colour 1, quads 1010) on line 2 -> pix_sg=1, pix_color=1, left 4 on, right 4 off; on line 8 -> left on, right off (bits1:0=10).
- 12*16+1 line_starts after frame_start -> text_row=16, pix_on=0 throughout, vram_addr unchanged.
- Assert reset mid-ACTIVE at column 10 -> outputs 0 same cycle, IDLE; next line_start restarts at column 0.
- clk_ena toggled every other clk -> pixel stream identical to full-rate run, each pixel held 2 clks.

Source files
------------

// File: rtl/vdg_text_pipeline.sv
// MC6847-style text/SG4 pixel generator: walks VRAM per character row, fetches glyph lines, serialises 8 px/char.
// First pixel 8 enabled cycles after line_start; everything stalls while clk_ena is low (no other backpressure).
module vdg_text_pipeline #(
    parameter int COLS    = 32,
    parameter int ROWS    = 16,
    parameter int CELL_H  = 12,
    parameter int GLYPH_H = 8,
    parameter int TOP_PAD = 3,
    parameter int ADDR_W  = 13,
    parameter int ROM_AW  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_ena,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] vram_base,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [7:0]        vram_data,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              pix_on,
    output logic              pix_sg,
    output logic [2:0]        pix_color,
    output logic              pix_valid
);
    localparam int GW = $clog2(GLYPH_H);
    localparam int CW = $clog2(COLS + 1);
    localparam int RW = $clog2(ROWS + 1);
    localparam int LW = (CELL_H > 2) ? $clog2(CELL_H) : 1;

    typedef enum logic [1:0] {IDLE, PREFETCH, ACTIVE} state_t;
    state_t state, state_nxt;

    logic [2:0]        k;
    logic [CW-1:0]     fetch_col;
    logic [RW-1:0]     text_row;
    logic [LW-1:0]     line_in_cell;
    logic              first_line;
    logic [7:0]        code, glyph, shifter;
    logic              sg_cur;
    logic [2:0]        color_cur;

    logic              row_off, fetch_ok, last_slot, pad, upper;
    logic [LW-1:0]     g;
    logic [1:0]        quad;
    logic [7:0]        text_bits;
    logic [ADDR_W-1:0] fetch_addr;

    always_comb begin
        row_off    = (int'(text_row) >= ROWS);
        fetch_ok   = !row_off && (int'(fetch_col) < COLS);
        last_slot  = (state == ACTIVE) && (k == 3'd7) && (int'(fetch_col) == COLS);
        g          = line_in_cell - LW'(TOP_PAD);
        pad        = (int'(line_in_cell) < TOP_PAD) || (int'(line_in_cell) - TOP_PAD >= GLYPH_H);
        upper      = (int'(line_in_cell) < CELL_H / 2);
        quad       = upper ? code[3:2] : code[1:0];
        text_bits  = code[6] ? ~glyph : glyph;
        fetch_addr = vram_base + ADDR_W'(int'(text_row) * COLS) + ADDR_W'(fetch_col);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        state <= IDLE;
        else if (clk_ena) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (line_start) state_nxt = PREFETCH;
            PREFETCH: if (line_start) state_nxt = PREFETCH;
                      else if (k == 3'd7) state_nxt = ACTIVE;
            ACTIVE:   if (line_start) state_nxt = PREFETCH;
                      else if (last_slot) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pix_valid = (state == ACTIVE);
        pix_on    = pix_valid & shifter[7];
        pix_sg    = pix_valid & sg_cur;
        pix_color = pix_valid ? color_cur : 3'd0;
    end

    // The first line_start after frame_start is line 0 of row 0; later ones advance the cell position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_in_cell <= '0;
            text_row     <= '0;
            first_line   <= 1'b1;
        end else if (clk_ena) begin
            if (frame_start) begin
                line_in_cell <= '0;
                text_row     <= '0;
                first_line   <= !line_start;
            end else if (line_start) begin
                if (first_line) begin
                    first_line <= 1'b0;
                end else if (int'(line_in_cell) == CELL_H - 1) begin
                    line_in_cell <= '0;
                    if (!row_off) text_row <= text_row + 1'b1;
                end else begin
                    line_in_cell <= line_in_cell + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k         <= '0;
            fetch_col <= '0;
            vram_addr <= '0;
            rom_addr  <= '0;
            code      <= '0;
            glyph     <= '0;
            shifter   <= '0;
            sg_cur    <= 1'b0;
            color_cur <= '0;
        end else if (clk_ena) begin
            if (line_start) begin
                k         <= '0;
                fetch_col <= '0;
                shifter   <= '0;
                sg_cur    <= 1'b0;
                color_cur <= '0;
            end else if (state != IDLE) begin
                k <= k + 1'b1;
                if (k == 3'd0 && fetch_ok) vram_addr <= fetch_addr;
                if (k == 3'd2) code <= vram_data;
                if (k == 3'd3 && !row_off) rom_addr <= ROM_AW'({code[5:0], g[GW-1:0]});
                if (k == 3'd5) glyph <= pad ? 8'h00 : rom_data;
                if (k == 3'd7) begin
                    fetch_col <= fetch_col + 1'b1;
                    if (row_off) begin
                        shifter   <= 8'h00;
                        sg_cur    <= 1'b0;
                        color_cur <= 3'd0;
                    end else if (code[7]) begin
                        shifter   <= {{4{quad[1]}}, {4{quad[0]}}};
                        sg_cur    <= 1'b1;
                        color_cur <= code[6:4];
                    end else begin
                        shifter   <= text_bits;
                        sg_cur    <= 1'b0;
                        color_cur <= 3'd0;
                    end
                end else begin
                    shifter <= {shifter[6:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_vdg_text_pipeline.sv
// Directed bench for vdg_text_pipeline: vector table of single characters plus line-length,
// row-overflow, mid-line reset and half-rate clk_ena sequences.
module tb_vdg_text_pipeline;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_ena = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic [12:0] vram_base = 13'h100;
    logic [12:0] vram_addr;
    logic [7:0]  vram_data = 8'h00;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        pix_on, pix_sg, pix_valid;
    logic [2:0]  pix_color;

    logic [7:0]  vram [0:8191];
    logic [7:0]  rom  [0:511];

    int checks = 0;
    int errors = 0;
    bit half = 1'b0;
    bit watch_hold = 1'b0;
    int hold_bad = 0;

    typedef struct {
        logic [7:0] code;
        int         line;
        logic [7:0] exp_px;
        logic       exp_sg;
        logic [2:0] exp_col;
    } vec_t;
    vec_t vecs [10];

    vdg_text_pipeline dut (
        .clk(clk), .reset(reset), .clk_ena(clk_ena),
        .frame_start(frame_start), .line_start(line_start),
        .vram_base(vram_base), .vram_addr(vram_addr), .vram_data(vram_data),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_on(pix_on), .pix_sg(pix_sg), .pix_color(pix_color), .pix_valid(pix_valid)
    );

    always #5 clk = ~clk;

    // Synchronous memories: data appears one enabled cycle after the address.
    always @(posedge clk) begin
        if (clk_ena) begin
            vram_data <= vram[vram_addr];
            rom_data  <= rom[rom_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One enabled cycle; in half-rate mode it is followed by a disabled clock whose outputs must not move.
    task automatic estep();
        logic [27:0] snap;
        if (half) begin
            clk_ena = 1'b1;
            @(posedge clk); #1;
            snap = {pix_on, pix_valid, pix_sg, pix_color, vram_addr, rom_addr};
            clk_ena = 1'b0;
            @(posedge clk); #1;
            if (watch_hold && snap !== {pix_on, pix_valid, pix_sg, pix_color, vram_addr, rom_addr})
                hold_bad++;
        end else begin
            clk_ena = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    // frame_start, then line_start pulses until line_in_cell == line; returns at the first visible pixel.
    task automatic start_line(input int line);
        frame_start = 1'b1;
        line_start  = 1'b1;
        estep();
        frame_start = 1'b0;
        for (int i = 0; i < line; i++) begin
            line_start = 1'b0;
            estep();
            line_start = 1'b1;
            estep();
        end
        line_start = 1'b0;
        repeat (8) estep();
    endtask

    task automatic grab(output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            b[7-i] = pix_on;
            estep();
        end
    endtask

    initial begin
        logic [7:0] b0, b1;
        int n, ones, addr_bad;

        for (int i = 0; i < 8192; i++) vram[i] = 8'h00;
        for (int i = 0; i < 512; i++) rom[i] = 8'h00;
        for (int i = 8; i < 16; i++) rom[i] = 8'hA5;

        vecs[0] = '{8'h01, 3,  8'hA5, 1'b0, 3'd0};
        vecs[1] = '{8'h41, 0,  8'hFF, 1'b0, 3'd0};
        vecs[2] = '{8'h41, 3,  8'h5A, 1'b0, 3'd0};
        vecs[3] = '{8'h9A, 2,  8'hF0, 1'b1, 3'd1};
        vecs[4] = '{8'h9A, 8,  8'hF0, 1'b1, 3'd1};
        vecs[5] = '{8'h01, 11, 8'h00, 1'b0, 3'd0};
        vecs[6] = '{8'h01, 10, 8'hA5, 1'b0, 3'd0};
        vecs[7] = '{8'h41, 11, 8'hFF, 1'b0, 3'd0};
        vecs[8] = '{8'h95, 9,  8'h0F, 1'b1, 3'd1};
        vecs[9] = '{8'hF5, 0,  8'h0F, 1'b1, 3'd7};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(pix_valid), 0);
        chk("reset_on", 32'(pix_on), 0);
        chk("reset_sg", 32'(pix_sg), 0);
        chk("reset_color", 32'(pix_color), 0);
        chk("reset_vram_addr", 32'(vram_addr), 0);
        chk("reset_rom_addr", 32'(rom_addr), 0);
        reset = 1'b0;
        clk_ena = 1'b1;

        for (int v = 0; v < 10; v++) begin
            vram[13'h100] = vecs[v].code;
            start_line(vecs[v].line);
            chk($sformatf("v%0d_valid", v), 32'(pix_valid), 1);
            chk($sformatf("v%0d_vram_addr", v), 32'(vram_addr), 32'h100);
            if (!vecs[v].code[7])
                chk($sformatf("v%0d_rom_addr", v), 32'(rom_addr),
                    32'(((vecs[v].code & 8'h3F) << 3) | ((vecs[v].line - 3) & 7)));
            chk($sformatf("v%0d_sg", v), 32'(pix_sg), 32'(vecs[v].exp_sg));
            chk($sformatf("v%0d_color", v), 32'(pix_color), 32'(vecs[v].exp_col));
            grab(b0);
            chk($sformatf("v%0d_pixels", v), 32'(b0), 32'(vecs[v].exp_px));
            if (v == 0) begin
                n = 8;
                while (pix_valid && n < 400) begin
                    n++;
                    estep();
                end
                chk("line_valid_len", 32'(n), 256);
            end
        end

        // Rows beyond the frame: blank but still "visible", and no new VRAM reads.
        vram[13'h100] = 8'h41;
        vram[13'h2E0] = 8'h41;
        start_line(12 * 16);
        n = 0; ones = 0; addr_bad = 0;
        while (pix_valid && n < 400) begin
            n++;
            if (pix_on) ones++;
            if (vram_addr !== 13'h2E0) addr_bad++;
            estep();
        end
        chk("rowoff_valid_len", 32'(n), 256);
        chk("rowoff_pix_on", 32'(ones), 0);
        chk("rowoff_addr_moves", 32'(addr_bad), 0);
        chk("rowoff_addr", 32'(vram_addr), 32'h2E0);

        // Reset in the middle of column 10.
        vram[13'h100] = 8'h41;
        vram[13'h10A] = 8'h41;
        start_line(0);
        repeat (10 * 8 + 3) estep();
        chk("pre_reset_valid", 32'(pix_valid), 1);
        chk("pre_reset_on", 32'(pix_on), 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_valid", 32'(pix_valid), 0);
        chk("mid_reset_on", 32'(pix_on), 0);
        chk("mid_reset_vram_addr", 32'(vram_addr), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) estep();
        chk("post_reset_idle", 32'(pix_valid), 0);
        start_line(0);
        chk("restart_vram_addr", 32'(vram_addr), 32'h100);
        grab(b0);
        chk("restart_pixels", 32'(b0), 32'hFF);

        // Full rate versus clk_ena every other clock.
        vram[13'h100] = 8'h01;
        vram[13'h101] = 8'h41;
        start_line(3);
        grab(b0);
        grab(b1);
        chk("full_rate_stream", 32'({b0, b1}), 32'hA55A);
        half = 1'b1;
        watch_hold = 1'b1;
        start_line(3);
        grab(b0);
        grab(b1);
        watch_hold = 1'b0;
        half = 1'b0;
        clk_ena = 1'b1;
        chk("half_rate_stream", 32'({b0, b1}), 32'hA55A);
        chk("half_rate_hold", 32'(hold_bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
